// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, icodes, register IDs and the W bubble.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package y86_pkg;

   // Processor status codes carried down the pipeline with each instruction.
   typedef enum logic [2:0] {
      STAT_AOK = 3'd1,
      STAT_HLT = 3'd2,
      STAT_ADR = 3'd3,
      STAT_INS = 3'd4
   } stat_e;

   // Instruction codes.
   typedef enum logic [3:0] {
      I_HALT   = 4'h0,
      I_NOP    = 4'h1,
      I_RRMOVQ = 4'h2,
      I_IRMOVQ = 4'h3,
      I_RMMOVQ = 4'h4,
      I_MRMOVQ = 4'h5,
      I_OPQ    = 4'h6,
      I_JXX    = 4'h7,
      I_CALL   = 4'h8,
      I_RET    = 4'h9,
      I_PUSHQ  = 4'hA,
      I_POPQ   = 4'hB
   } icode_e;

   localparam logic [3:0] RNONE   = 4'hF;
   localparam logic [3:0] REG_RSP = 4'h4;

   // Bubble loaded into W: a NOP that reports AOK and writes nothing.
   // Destination fields of the bubble are the all-ones RNONE of whatever width is used.
   localparam logic [2:0] W_BUBBLE_STAT  = STAT_AOK;
   localparam logic [3:0] W_BUBBLE_ICODE = I_NOP;

   // True for the statuses that stop the machine.
   function automatic logic is_stop_stat(input logic [2:0] stat);
      return (stat == STAT_HLT) || (stat == STAT_ADR) || (stat == STAT_INS);
   endfunction

endpackage

// File: rtl/y86_regfile.sv
// Register file: two write ports (M beats E on a shared destination), two bypassed reads, flat dump.
// Latency: write lands on the edge; reads are combinational with same-cycle bypass of the pending write.
// Backpressure: none; the caller gates writes with we.
// Ports: clk/rst (sync, active-high); we; dstE/valE and dstM/valM write ports;
//        srcA/srcB -> rd_valA/rd_valB bypassed reads; reg_dump architectural state, reg i at [i*DATA_W +: DATA_W].
module y86_regfile
   import y86_pkg::*;
#(
   parameter int                NUM_REGS = 15,
   parameter int                DATA_W   = 64,
   parameter int                REG_ID_W = 4,
   parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we,
   input  logic [REG_ID_W-1:0]          dstE,
   input  logic [DATA_W-1:0]            valE,
   input  logic [REG_ID_W-1:0]          dstM,
   input  logic [DATA_W-1:0]            valM,
   input  logic [REG_ID_W-1:0]          srcA,
   input  logic [REG_ID_W-1:0]          srcB,
   output logic [DATA_W-1:0]            rd_valA,
   output logic [DATA_W-1:0]            rd_valB,
   output logic [NUM_REGS*DATA_W-1:0]   reg_dump
);

   localparam logic [REG_ID_W-1:0] RNONE_ID = '1;

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   // IDs at or above NUM_REGS name no register; RNONE is excluded explicitly in case
   // NUM_REGS fills the whole ID space.
   function automatic logic id_ok(input logic [REG_ID_W-1:0] id);
      return (id != RNONE_ID) && (int'(id) < NUM_REGS);
   endfunction

   logic weE, weM;
   assign weE = we && id_ok(dstE);
   assign weM = we && id_ok(dstM);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= (REG_ID_W'(i) == REG_ID_W'(REG_RSP)) ? RSP_INIT : '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            // M checked first so popq %rsp keeps the loaded value, not the incremented pointer.
            if (weM && dstM == REG_ID_W'(i)) begin
               regs_q[i] <= valM;
            end else if (weE && dstE == REG_ID_W'(i)) begin
               regs_q[i] <= valE;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_dump
      assign reg_dump[g*DATA_W +: DATA_W] = regs_q[g];
   end

   // Decode sees the value W is about to write, with the same M-over-E priority as the array.
   function automatic logic [DATA_W-1:0] read_port(input logic [REG_ID_W-1:0]        src,
                                                    input logic [NUM_REGS*DATA_W-1:0] dump);
      if (!id_ok(src))                return '0;
      else if (weM && src == dstM)    return valM;
      else if (weE && src == dstE)    return valE;
      else                            return dump[int'(src)*DATA_W +: DATA_W];
   endfunction

   assign rd_valA = read_port(srcA, reg_dump);
   assign rd_valB = read_port(srcB, reg_dump);

endmodule

// File: rtl/y86_wb_regfile.sv
// Write-back stage: W pipeline register with stall/bubble, sticky halt, and the register file it writes.
// Latency: m_* captured on edge 1, bypass-visible after edge 1, architectural after edge 2.
// Backpressure: W_stall holds W (and repeats its write); W_bubble replaces it with a NOP; stall wins.
// Ports: clk/rst (sync, active-high); W_stall/W_bubble control; m_stat/m_icode/m_dstE/m_valE/m_dstM/m_valM
//        from memory; srcA/srcB -> rd_valA/rd_valB for decode; W_stat/W_icode/halted status; reg_dump.
module y86_wb_regfile
   import y86_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter int                NUM_REGS = 15,
   parameter int                REG_ID_W = 4,
   parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         W_stall,
   input  logic                         W_bubble,
   input  logic [2:0]                   m_stat,
   input  logic [3:0]                   m_icode,
   input  logic [REG_ID_W-1:0]          m_dstE,
   input  logic [DATA_W-1:0]            m_valE,
   input  logic [REG_ID_W-1:0]          m_dstM,
   input  logic [DATA_W-1:0]            m_valM,
   input  logic [REG_ID_W-1:0]          srcA,
   input  logic [REG_ID_W-1:0]          srcB,
   output logic [DATA_W-1:0]            rd_valA,
   output logic [DATA_W-1:0]            rd_valB,
   output logic [2:0]                   W_stat,
   output logic [3:0]                   W_icode,
   output logic                         halted,
   output logic [NUM_REGS*DATA_W-1:0]   reg_dump
);

   logic [2:0]          w_stat_q,  w_stat_d;
   logic [3:0]          w_icode_q, w_icode_d;
   logic [REG_ID_W-1:0] w_dstE_q,  w_dstE_d;
   logic [DATA_W-1:0]   w_valE_q,  w_valE_d;
   logic [REG_ID_W-1:0] w_dstM_q,  w_dstM_d;
   logic [DATA_W-1:0]   w_valM_q,  w_valM_d;
   logic                halted_q,  halted_d;
   logic                wr_en;

   // A faulting instruction never writes, and nothing writes once stopped.
   assign wr_en = (w_stat_q == STAT_AOK) && !halted_q;

   always_comb begin
      w_stat_d  = w_stat_q;
      w_icode_d = w_icode_q;
      w_dstE_d  = w_dstE_q;
      w_valE_d  = w_valE_q;
      w_dstM_d  = w_dstM_q;
      w_valM_d  = w_valM_q;
      halted_d  = halted_q || is_stop_stat(w_stat_q);
      if (W_stall) begin
         // hold
      end else if (W_bubble) begin
         w_stat_d  = W_BUBBLE_STAT;
         w_icode_d = W_BUBBLE_ICODE;
         w_dstE_d  = '1;
         w_valE_d  = '0;
         w_dstM_d  = '1;
         w_valM_d  = '0;
      end else begin
         w_stat_d  = m_stat;
         w_icode_d = m_icode;
         w_dstE_d  = m_dstE;
         w_valE_d  = m_valE;
         w_dstM_d  = m_dstM;
         w_valM_d  = m_valM;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_stat_q  <= W_BUBBLE_STAT;
         w_icode_q <= W_BUBBLE_ICODE;
         w_dstE_q  <= '1;
         w_valE_q  <= '0;
         w_dstM_q  <= '1;
         w_valM_q  <= '0;
         halted_q  <= 1'b0;
      end else begin
         w_stat_q  <= w_stat_d;
         w_icode_q <= w_icode_d;
         w_dstE_q  <= w_dstE_d;
         w_valE_q  <= w_valE_d;
         w_dstM_q  <= w_dstM_d;
         w_valM_q  <= w_valM_d;
         halted_q  <= halted_d;
      end
   end

   assign W_stat  = w_stat_q;
   assign W_icode = w_icode_q;
   assign halted  = halted_q;

   y86_regfile #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W),
      .REG_ID_W (REG_ID_W),
      .RSP_INIT (RSP_INIT)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we       (wr_en),
      .dstE     (w_dstE_q),
      .valE     (w_valE_q),
      .dstM     (w_dstM_q),
      .valM     (w_valM_q),
      .srcA     (srcA),
      .srcB     (srcB),
      .rd_valA  (rd_valA),
      .rd_valB  (rd_valB),
      .reg_dump (reg_dump)
   );

endmodule

// File: tb/tb_y86_wb_regfile.sv
// Bench for y86_wb_regfile: directed scenarios then random traffic against an array-based reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_y86_wb_regfile;
   localparam int          DATA_W   = 64;
   localparam int          NUM_REGS = 15;
   localparam int          REG_ID_W = 4;
   localparam logic [63:0] RSP_INIT = 64'd256;

   logic          clk = 1'b0;
   logic          rst;
   logic          W_stall, W_bubble;
   logic [2:0]    m_stat;
   logic [3:0]    m_icode;
   logic [3:0]    m_dstE, m_dstM;
   logic [63:0]   m_valE, m_valM;
   logic [3:0]    srcA, srcB;
   logic [63:0]   rd_valA, rd_valB;
   logic [2:0]    W_stat;
   logic [3:0]    W_icode;
   logic          halted;
   logic [NUM_REGS*DATA_W-1:0] reg_dump;

   always #5 clk = ~clk;

   y86_wb_regfile #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .REG_ID_W(REG_ID_W), .RSP_INIT(RSP_INIT)
   ) dut (
      .clk(clk), .rst(rst), .W_stall(W_stall), .W_bubble(W_bubble),
      .m_stat(m_stat), .m_icode(m_icode), .m_dstE(m_dstE), .m_valE(m_valE),
      .m_dstM(m_dstM), .m_valM(m_valM), .srcA(srcA), .srcB(srcB),
      .rd_valA(rd_valA), .rd_valB(rd_valB), .W_stat(W_stat), .W_icode(W_icode),
      .halted(halted), .reg_dump(reg_dump)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: what the architecture holds, what sits in W, and whether the machine stopped.
   logic [63:0] ref_regs [NUM_REGS];
   logic [2:0]  rw_stat;
   logic [3:0]  rw_icode, rw_dstE, rw_dstM;
   logic [63:0] rw_valE, rw_valM;
   logic        ref_halted;

   function automatic logic dst_real(input logic [3:0] d);
      return (d != 4'hF) && (int'(d) < NUM_REGS);
   endfunction

   function automatic logic ref_we();
      return (rw_stat == 3'd1) && !ref_halted;
   endfunction

   function automatic logic [63:0] ref_read(input logic [3:0] src);
      if (!dst_real(src))                   return 64'd0;
      if (ref_we() && src == rw_dstM)       return rw_valM;
      if (ref_we() && src == rw_dstE)       return rw_valE;
      return ref_regs[src];
   endfunction

   task automatic ref_bubble();
      rw_stat = 3'd1; rw_icode = 4'd1; rw_dstE = 4'hF; rw_dstM = 4'hF;
      rw_valE = 64'd0; rw_valM = 64'd0;
   endtask

   task automatic ref_edge();
      if (rst) begin
         foreach (ref_regs[i]) ref_regs[i] = 64'd0;
         ref_regs[4] = RSP_INIT;
         ref_bubble();
         ref_halted = 1'b0;
      end else begin
         if (ref_we() && dst_real(rw_dstE)) ref_regs[rw_dstE] = rw_valE;
         if (ref_we() && dst_real(rw_dstM)) ref_regs[rw_dstM] = rw_valM;
         if (rw_stat >= 3'd2 && rw_stat <= 3'd4) ref_halted = 1'b1;
         if (W_stall) begin
         end else if (W_bubble) begin
            ref_bubble();
         end else begin
            rw_stat = m_stat; rw_icode = m_icode; rw_dstE = m_dstE; rw_valE = m_valE;
            rw_dstM = m_dstM; rw_valM = m_valM;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NUM_REGS; i++)
         check_val($sformatf("reg%0d", i), reg_dump[i*DATA_W +: DATA_W], ref_regs[i]);
      check_val("rd_valA", rd_valA, ref_read(srcA));
      check_val("rd_valB", rd_valB, ref_read(srcB));
      check_val("W_stat", 64'(W_stat), 64'(rw_stat));
      check_val("W_icode", 64'(W_icode), 64'(rw_icode));
      check_val("halted", 64'(halted), 64'(ref_halted));
   endtask

   // One clock: reference steps on the same inputs the DUT samples, then compare 1ns later.
   task automatic tick();
      @(posedge clk);
      ref_edge();
      #1;
      check_all();
   endtask

   task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                        input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
      m_stat = st; m_icode = ic; m_dstE = de; m_valE = ve; m_dstM = dm; m_valM = vm;
   endtask

   task automatic drive_idle();
      drive(3'd1, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0);
   endtask

   function automatic logic [63:0] dump_reg(input int i);
      return reg_dump[i*DATA_W +: DATA_W];
   endfunction

   initial begin
      rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
      srcA = 4'd4; srcB = 4'd0;
      drive_idle();
      tick(); tick();
      rst = 1'b0;
      #1;
      // Reset state
      check_val("rst_reg4", dump_reg(4), 64'd256);
      check_val("rst_reg0", dump_reg(0), 64'd0);
      check_val("rst_Wstat", 64'(W_stat), 64'd1);
      check_val("rst_Wicode", 64'(W_icode), 64'd1);
      check_val("rst_halted", 64'(halted), 64'd0);
      check_val("rst_rdA_rsp", rd_valA, 64'd256);

      // irmovq $5, %rbx
      drive(3'd1, 4'd3, 4'd3, 64'd5, 4'hF, 64'd0);
      srcA = 4'd3;
      tick();
      check_val("irmov_bypass", rd_valA, 64'd5);
      check_val("irmov_reg3_pre", dump_reg(3), 64'd0);
      drive_idle();
      tick();
      check_val("irmov_reg3", dump_reg(3), 64'd5);

      // popq %rsp: both ports on reg 4, M wins
      drive(3'd1, 4'hB, 4'd4, 64'd100, 4'd4, 64'd200);
      srcB = 4'd4;
      tick();
      check_val("pop_bypassB", rd_valB, 64'd200);
      drive_idle();
      tick();
      check_val("pop_reg4", dump_reg(4), 64'd200);

      // Stall with a write to reg1 held in W, then bubble
      drive(3'd1, 4'd3, 4'd1, 64'd7, 4'hF, 64'd0);
      tick();
      W_stall = 1'b1;
      drive(3'd1, 4'd3, 4'd2, 64'd99, 4'hF, 64'd0);
      tick(); tick();
      check_val("stall_reg1", dump_reg(1), 64'd7);
      check_val("stall_reg2", dump_reg(2), 64'd0);
      check_val("stall_icode", 64'(W_icode), 64'd3);
      W_stall = 1'b0; W_bubble = 1'b1;
      tick();
      check_val("bubble_icode", 64'(W_icode), 64'd1);
      tick();
      check_val("bubble_reg2", dump_reg(2), 64'd0);
      W_bubble = 1'b0;

      // Address fault: no write, sticky halt, later writes suppressed, reset clears
      drive(3'd3, 4'd5, 4'd2, 64'd9, 4'hF, 64'd0);
      tick();
      drive(3'd1, 4'd3, 4'd5, 64'd11, 4'hF, 64'd0);
      tick();
      check_val("adr_halted", 64'(halted), 64'd1);
      check_val("adr_reg2", dump_reg(2), 64'd0);
      drive_idle();
      tick(); tick();
      check_val("adr_reg5", dump_reg(5), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("rst_clears_halt", 64'(halted), 64'd0);

      // Top register with all-ones data
      drive(3'd1, 4'd3, 4'd14, '1, 4'hF, 64'd0);
      tick();
      drive_idle();
      tick();
      check_val("reg14_ones", dump_reg(14), '1);

      // RNONE destination writes nothing (full-state compare in tick)
      drive(3'd1, 4'd3, 4'hF, 64'd123, 4'hF, 64'd456);
      tick(); tick();
      srcA = 4'hF;
      #1;
      check_val("srcA_rnone", rd_valA, 64'd0);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         int r;
         rst      = ($urandom_range(0, 59) == 0);
         W_stall  = ($urandom_range(0, 7) == 0);
         W_bubble = ($urandom_range(0, 7) == 0);
         r = $urandom_range(0, 59);
         m_stat   = (r == 0) ? 3'd2 : (r == 1) ? 3'd3 : (r == 2) ? 3'd4 : 3'd1;
         m_icode  = 4'($urandom_range(0, 11));
         m_dstE   = 4'($urandom_range(0, 15));
         m_dstM   = ($urandom_range(0, 3) == 0) ? m_dstE : 4'($urandom_range(0, 15));
         m_valE   = {$urandom, $urandom};
         m_valM   = {$urandom, $urandom};
         srcA     = 4'($urandom_range(0, 15));
         srcB     = 4'($urandom_range(0, 15));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Safety net against a stuck run.
   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

endmodule
